// File: rtl/dm_arbiter_if.sv
// One requester's view of the data-memory arbiter: request, lock, address, write data,
// plus the grant and registered read-return signals.
interface dm_arbiter_if #(
  parameter int unsigned DW      = 32,
  parameter int unsigned ADDR_HI = 8
);
  logic               req;
  logic               we;
  logic               lock;
  logic [ADDR_HI:2]   addr;
  logic [DW-1:0]      wdata;
  logic               gnt;
  logic               rvalid;
  logic [DW-1:0]      rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the CPU (m0) and a debug/DMA loader (m1).
// Round-robin with per-port lock; define DM_ARB_FIXED_PRIO_EN to make m0 win every tie in FREE.
module dm_arbiter #(
  parameter int unsigned DW      = 32,
  parameter int unsigned ADDR_HI = 8
) (
  input  logic              clk,
  input  logic              rst,
  dm_arbiter_if.slave       m0,
  dm_arbiter_if.slave       m1,
  output logic              dm_we,
  output logic [ADDR_HI:2]  dm_addr,
  output logic [DW-1:0]     dm_din,
  input  logic [DW-1:0]     dm_dout
);

`ifdef DM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t          state;
  logic            last;
  logic            gnt0;
  logic            gnt1;
  logic            tie_to_0;
  logic            rvalid0;
  logic            rvalid1;
  logic [DW-1:0]   rdata0;
  logic [DW-1:0]   rdata1;

  // A tie in FREE goes to port 0 when port 1 was served last (or always, with fixed priority).
  assign tie_to_0 = FIXED_PRIO | last;

  // Grant decode; reset forces both grants low so an in-flight write is dropped.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      unique case (state)
        FREE: begin
          if (m0.req && m1.req) begin
            gnt0 = tie_to_0;
            gnt1 = ~tie_to_0;
          end else begin
            gnt0 = m0.req;
            gnt1 = m1.req;
          end
        end
        LOCK0:   gnt0 = m0.req;
        LOCK1:   gnt1 = m1.req;
        default: ;
      endcase
    end
  end

  // Memory-side mux: port 0 drives the bus whenever port 1 is not granted.
  assign dm_addr = gnt1 ? m1.addr  : m0.addr;
  assign dm_din  = gnt1 ? m1.wdata : m0.wdata;
  assign dm_we   = (gnt0 & m0.we) | (gnt1 & m1.we);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FREE;
      last    <= 1'b1;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~m0.we;
      rvalid1 <= gnt1 & ~m1.we;
      if (gnt0 && !m0.we) rdata0 <= dm_dout;
      if (gnt1 && !m1.we) rdata1 <= dm_dout;

      // Ownership: a granted port keeps the memory while it holds lock; an idle owner may release.
      if (gnt0) begin
        last  <= 1'b0;
        state <= m0.lock ? LOCK0 : FREE;
      end else if (gnt1) begin
        last  <= 1'b1;
        state <= m1.lock ? LOCK1 : FREE;
      end else if (state == LOCK0 && !m0.req && !m0.lock) begin
        state <= FREE;
      end else if (state == LOCK1 && !m1.req && !m1.lock) begin
        state <= FREE;
      end
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.rdata  = rdata0;
  assign m1.rdata  = rdata1;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: ownership/priority model with a shadow memory checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dm_arbiter;
  localparam int unsigned DW      = 32;
  localparam int unsigned ADDR_HI = 8;
  localparam int unsigned AW      = ADDR_HI - 1;
  localparam int unsigned DEPTH   = 1 << AW;

`ifdef DM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              dm_we;
  logic [ADDR_HI:2]  dm_addr;
  logic [DW-1:0]     dm_din;
  logic [DW-1:0]     dm_dout;
  logic [DW-1:0]     mem [DEPTH];

  dm_arbiter_if #(.DW(DW), .ADDR_HI(ADDR_HI)) m0_if ();
  dm_arbiter_if #(.DW(DW), .ADDR_HI(ADDR_HI)) m1_if ();

  dm_arbiter #(.DW(DW), .ADDR_HI(ADDR_HI)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .dm_we   (dm_we),
    .dm_addr (dm_addr),
    .dm_din  (dm_din),
    .dm_dout (dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: async read, write on rising edge.
  assign dm_dout = mem[dm_addr];
  always @(posedge clk) if (dm_we) mem[dm_addr] = dm_din;

  // Model state: owner -1 means nobody holds a lock.
  int            owner;
  int            last;
  bit            chk_en;
  logic [DW-1:0] shadow [DEPTH];
  bit            exp_rv [2];
  logic [DW-1:0] exp_rd [2];
  int            glog [$];
  int            checks;
  int            errors;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model to the next edge.
  always @(negedge clk) begin : compare
    logic          r [2];
    logic          w [2];
    logic          l [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    int            win;
    bit            exp_we;
    if (chk_en) begin
      r[0] = m0_if.req;  w[0] = m0_if.we;  l[0] = m0_if.lock;  a[0] = m0_if.addr;  d[0] = m0_if.wdata;
      r[1] = m1_if.req;  w[1] = m1_if.we;  l[1] = m1_if.lock;  a[1] = m1_if.addr;  d[1] = m1_if.wdata;
      win = -1;
      if (!rst) begin
        if (owner >= 0) begin
          if (r[owner]) win = owner;
        end else if (r[0] && r[1]) begin
          win = FIXED ? 0 : 1 - last;
        end else if (r[0]) begin
          win = 0;
        end else if (r[1]) begin
          win = 1;
        end
      end
      exp_we = 1'b0;
      if (win >= 0) exp_we = w[win];

      chk("gnt0",    DW'(m0_if.gnt), DW'(win == 0));
      chk("gnt1",    DW'(m1_if.gnt), DW'(win == 1));
      chk("dm_we",   DW'(dm_we),     DW'(exp_we));
      chk("dm_addr", DW'(dm_addr),   DW'((win == 1) ? a[1] : a[0]));
      if (exp_we) chk("dm_din", dm_din, d[win]);
      chk("rvalid0", DW'(m0_if.rvalid), DW'(exp_rv[0]));
      chk("rvalid1", DW'(m1_if.rvalid), DW'(exp_rv[1]));
      chk("rdata0",  m0_if.rdata, exp_rd[0]);
      chk("rdata1",  m1_if.rdata, exp_rd[1]);

      if (rst) begin
        owner = -1;
        last  = 1;
        exp_rv[0] = 1'b0;  exp_rv[1] = 1'b0;
        exp_rd[0] = '0;    exp_rd[1] = '0;
      end else begin
        glog.push_back(win);
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        if (win >= 0) begin
          last  = win;
          owner = l[win] ? win : -1;
          if (w[win]) begin
            shadow[a[win]] = d[win];
          end else begin
            exp_rv[win] = 1'b1;
            exp_rd[win] = shadow[a[win]];
          end
        end else if (owner >= 0 && !r[owner] && !l[owner]) begin
          owner = -1;
        end
      end
    end
  end

  task automatic drv(input int p, input bit req, input bit we, input bit lk,
                     input int addr, input logic [DW-1:0] d);
    if (p == 0) begin
      m0_if.req = req;  m0_if.we = we;  m0_if.lock = lk;  m0_if.addr = AW'(addr);  m0_if.wdata = d;
    end else begin
      m1_if.req = req;  m1_if.we = we;  m1_if.lock = lk;  m1_if.addr = AW'(addr);  m1_if.wdata = d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Unlocked single access with a bounded wait for the grant.
  task automatic access(input int p, input bit we, input int addr, input logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    drv(p, 1'b1, we, 1'b0, addr, d);
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? m0_if.gnt : m1_if.gnt;
    end
    chk("access_grant_timeout", DW'(got), DW'(1));
    step();
    drv(p, 1'b0, 1'b0, 1'b0, addr, d);
  endtask

  task automatic chk_log(input string name, input int exp[6], input int n);
    chk({name, "_len"}, DW'(glog.size()), DW'(n));
    for (int i = 0; i < n && i < glog.size(); i++)
      chk($sformatf("%s_%0d", name, i), DW'(glog[i]), DW'(exp[i]));
  endtask

  initial begin : main
    int t3 [6];
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    owner  = -1;
    last   = 1;
    exp_rv[0] = 1'b0;  exp_rv[1] = 1'b0;
    exp_rd[0] = '0;    exp_rd[1] = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]    = 32'h1000_0000 + DW'(i);
      shadow[i] = 32'h1000_0000 + DW'(i);
    end

    // Reset held with both ports requesting.
    rst = 1'b1;
    drv(0, 1'b1, 1'b0, 1'b0, 1, '0);
    drv(1, 1'b1, 1'b1, 1'b0, 2, 32'h1234_5678);
    step();
    chk_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t1_gnt0",    DW'(m0_if.gnt),    '0);
      chk("t1_gnt1",    DW'(m1_if.gnt),    '0);
      chk("t1_dm_we",   DW'(dm_we),        '0);
      chk("t1_rvalid1", DW'(m1_if.rvalid), '0);
      step();
    end
    rst = 1'b0;
    drv(0, 1'b0, 1'b0, 1'b0, 0, '0);
    drv(1, 1'b0, 1'b0, 1'b0, 0, '0);
    step();

    // m0 writes, m1 reads the same word back.
    access(0, 1'b1, 5, 32'hDEAD_BEEF);
    chk("t2_mem5", mem[5], 32'hDEAD_BEEF);
    access(1, 1'b0, 5, '0);
    @(negedge clk);
    chk("t2_rvalid1", DW'(m1_if.rvalid), DW'(1));
    chk("t2_rdata1",  m1_if.rdata,       32'hDEAD_BEEF);
    step();

    // Both ports read continuously for 6 cycles; m1 was served last.
    glog.delete();
    drv(0, 1'b1, 1'b0, 1'b0, 5, '0);
    drv(1, 1'b1, 1'b0, 1'b0, 7, '0);
    repeat (6) step();
    drv(0, 1'b0, 1'b0, 1'b0, 0, '0);
    drv(1, 1'b0, 1'b0, 1'b0, 0, '0);
    if (FIXED) t3 = '{0, 0, 0, 0, 0, 0};
    else       t3 = '{0, 1, 0, 1, 0, 1};
    chk_log("t3_grants", t3, 6);
    step();

    // m1 locks for 3 writes while m0 waits, then releases.
    glog.delete();
    drv(1, 1'b1, 1'b1, 1'b1, 8'h20, 32'hCAFE_0000);
    step();
    drv(0, 1'b1, 1'b1, 1'b0, 8'h10, 32'h0BAD_F00D);
    drv(1, 1'b1, 1'b1, 1'b1, 8'h21, 32'hCAFE_0001);
    step();
    drv(1, 1'b1, 1'b1, 1'b1, 8'h22, 32'hCAFE_0002);
    step();
    drv(1, 1'b0, 1'b0, 1'b0, 0, '0);
    step();
    step();
    drv(0, 1'b0, 1'b0, 1'b0, 0, '0);
    chk_log("t4_grants", '{1, 1, 1, -1, 0, 0}, 5);
    chk("t4_mem22", mem[8'h22], 32'hCAFE_0002);
    chk("t4_mem10", mem[8'h10], 32'h0BAD_F00D);
    step();

    // Reset lands on a cycle where a locked m0 would have written.
    drv(0, 1'b1, 1'b0, 1'b1, 3, '0);
    step();
    drv(0, 1'b1, 1'b1, 1'b0, 8'h30, 32'hFFFF_0000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    glog.delete();
    drv(0, 1'b1, 1'b0, 1'b0, 1, '0);
    drv(1, 1'b1, 1'b0, 1'b0, 2, '0);
    step();
    drv(0, 1'b0, 1'b0, 1'b0, 0, '0);
    drv(1, 1'b0, 1'b0, 1'b0, 0, '0);
    chk("t5_mem30", mem[8'h30], 32'h1000_0030);
    chk_log("t5_grants", '{0, 0, 0, 0, 0, 0}, 1);
    step();

    // m1 alone, back-to-back reads of words 0..3.
    for (int i = 0; i < 4; i++) begin
      drv(1, 1'b1, 1'b0, 1'b0, i, '0);
      @(negedge clk);
      chk($sformatf("t6_gnt1_%0d", i), DW'(m1_if.gnt), DW'(1));
      if (i > 0) begin
        chk($sformatf("t6_rvalid_%0d", i), DW'(m1_if.rvalid), DW'(1));
        chk($sformatf("t6_rdata_%0d", i),  m1_if.rdata, 32'h1000_0000 + DW'(i - 1));
      end
      step();
    end
    drv(1, 1'b0, 1'b0, 1'b0, 0, '0);
    @(negedge clk);
    chk("t6_rvalid_last", DW'(m1_if.rvalid), DW'(1));
    chk("t6_rdata_last",  m1_if.rdata,       32'h1000_0003);
    step();
    @(negedge clk);
    chk("t6_rvalid_off",  DW'(m1_if.rvalid), '0);
    chk("t6_rdata_hold",  m1_if.rdata,       32'h1000_0003);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
